// File: rtl/tt_av_out_formatter_if.sv
// tt_av_out_formatter_if: video, audio and TT pin bundle between a generator and the output formatter
// rgb/active/hsync/vsync/dither_en: pixel stream; audio_sample/audio_valid: PCM load
// uo_out/uio_out/uio_oe: TT pin drive returned by the formatter
interface tt_av_out_formatter_if #(
  parameter int COLOR_BITS = 3,
  parameter int AUDIO_CH   = 1,
  parameter int AUDIO_BITS = 8
);
  logic [3*COLOR_BITS-1:0]        rgb;
  logic                           active;
  logic                           hsync;
  logic                           vsync;
  logic                           dither_en;
  logic [AUDIO_CH*AUDIO_BITS-1:0] audio_sample;
  logic                           audio_valid;
  logic [7:0]                     uo_out;
  logic [7:0]                     uio_out;
  logic [7:0]                     uio_oe;
  modport master (
    output rgb, active, hsync, vsync, dither_en, audio_sample, audio_valid,
    input  uo_out, uio_out, uio_oe
  );
  modport slave (
    input  rgb, active, hsync, vsync, dither_en, audio_sample, audio_valid,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_av_out_formatter.sv
// tt_av_out_formatter: RGB222 TinyVGA pin formatter with dithering, sigma-delta audio and button pulse
// clk, rst_n (sync, active low); bus: slave side of tt_av_out_formatter_if
// advance_raw: async button in; advance_pulse: one-cycle pulse per synchronised rising edge
module tt_av_out_formatter #(
  parameter int COLOR_BITS   = 3,
  parameter int AUDIO_CH     = 1,
  parameter int AUDIO_BITS   = 8,
  parameter int PIPE_DEPTH   = 1,
  parameter bit SYNC_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tt_av_out_formatter_if.slave  bus,
  input  logic                  advance_raw,
  output logic                  advance_pulse
);
  localparam int CB = COLOR_BITS;
  localparam int AB = AUDIO_BITS;
  localparam logic S = SYNC_ACT_LOW;
  localparam logic [7:0] IDLE = {S, 3'b0, S, 3'b0};
  logic x, y, hs_prev;
  logic [1:0] t;
  logic [1:0] q [3];
  logic [7:0] pix;
  logic [7:0] pipe [PIPE_DEPTH];
  logic [AB-1:0] smp [AUDIO_CH];
  logic [AB:0] acc [AUDIO_CH];
  logic [7:0] aud;
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= 1'b0;
      y <= 1'b0;
      hs_prev <= 1'b0;
    end else begin
      x <= bus.active & ~x;
      hs_prev <= bus.hsync;
      y <= ~bus.vsync & (y ^ (bus.hsync & ~hs_prev));
    end
  end
  // 2x2 Bayer threshold {0,2,3,1} indexed by {y,x}
  assign t = {x ^ y, y};
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [CB-1:0] c;
    logic [1:0] lvl;
    assign c = bus.rgb[i*CB +: CB];
    if (CB == 1) begin : g_one
      assign lvl = {c, c};
    end else if (CB == 2) begin : g_two
      assign lvl = c;
    end else begin : g_dith
      // two zero bits below the LSB give the error term for CB=3 for free
      logic [CB+1:0] cp;
      logic [1:0] top, e;
      assign cp = {c, 2'b00};
      assign top = cp[CB+1 -: 2];
      assign e = cp[CB-1 -: 2];
      assign lvl = (bus.dither_en && e > t && top != 2'd3) ? top + 2'd1 : top;
    end
    assign q[i] = bus.active ? lvl : 2'b00;
  end
  assign pix = {bus.hsync ^ S, q[0][0], q[1][0], q[2][0], bus.vsync ^ S, q[0][1], q[1][1], q[2][1]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) pipe[k] <= IDLE;
    end else begin
      pipe[0] <= pix;
      for (int k = 1; k < PIPE_DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign bus.uo_out = pipe[PIPE_DEPTH-1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < AUDIO_CH; k++) begin
        smp[k] <= '0;
        acc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < AUDIO_CH; k++) begin
        if (bus.audio_valid) smp[k] <= bus.audio_sample[k*AB +: AB];
        acc[k] <= {1'b0, acc[k][AB-1:0]} + {1'b0, smp[k]};
      end
    end
  end
  always_comb begin
    aud = '0;
    for (int k = 0; k < AUDIO_CH; k++) aud[7-k] = acc[k][AB];
  end
  assign bus.uio_out = aud;
  assign bus.uio_oe = ~(8'hFF >> AUDIO_CH);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      advance_pulse <= 1'b0;
    end else begin
      s1 <= advance_raw;
      s2 <= s1;
      s3 <= s2;
      advance_pulse <= s2 & ~s3;
    end
  end
endmodule

// File: tb/tb_tt_av_out_formatter.sv
// tb_tt_av_out_formatter: self-checking bench for tt_av_out_formatter
module tb_tt_av_out_formatter;
  localparam int CB = 4, AC = 2, AB = 8, PD = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic advance_raw = 1'b0;
  logic advance_pulse;
  int checks = 0;
  int errors = 0;
  tt_av_out_formatter_if #(.COLOR_BITS(CB), .AUDIO_CH(AC), .AUDIO_BITS(AB)) bus ();
  tt_av_out_formatter #(
    .COLOR_BITS(CB), .AUDIO_CH(AC), .AUDIO_BITS(AB), .PIPE_DEPTH(PD), .SYNC_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .advance_raw(advance_raw), .advance_pulse(advance_pulse)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] r, g, b;
    logic act, hs, vs, d;
    logic [7:0] exp;
  } vec_t;
  vec_t vec [10];
  logic [7:0] exq [$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [11:0] rgb, input logic act, hs, vs, d);
    bus.rgb = rgb;
    bus.active = act;
    bus.hsync = hs;
    bus.vsync = vs;
    bus.dither_en = d;
  endtask
  // Expected pins from the colour-reduction rules, using plain integer arithmetic
  function automatic logic [7:0] model(input logic [11:0] rgb, input logic act, hs, vs, d, px, py);
    int t, v, top, e, res;
    int lvl [3];
    t = py ? (px ? 1 : 3) : (px ? 2 : 0);
    for (int c = 0; c < 3; c++) begin
      v = (rgb >> (4 * c)) & 15;
      top = v / 4;
      e = v % 4;
      lvl[c] = !act ? 0 : (d && e > t && top < 3) ? top + 1 : top;
    end
    res = (hs ? 0 : 128) + (lvl[0] % 2) * 64 + (lvl[1] % 2) * 32 + (lvl[2] % 2) * 16
        + (vs ? 0 : 8) + (lvl[0] / 2) * 4 + (lvl[1] / 2) * 2 + lvl[2] / 2;
    return res[7:0];
  endfunction
  task automatic audio_window(input int s0, input int s1);
    int n0, n1, lo;
    bus.audio_sample = {s1[7:0], s0[7:0]};
    bus.audio_valid = 1'b1;
    @(posedge clk); #1;
    bus.audio_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n0 = 0; n1 = 0; lo = 0;
    for (int c = 0; c < 256; c++) begin
      n0 += int'(bus.uio_out[7]);
      n1 += int'(bus.uio_out[6]);
      if (bus.uio_out[5:0] != 6'd0) lo++;
      @(posedge clk); #1;
    end
    check($sformatf("audio_ch0_s%0d", s0), n0, s0);
    check($sformatf("audio_ch1_s%0d", s1), n1, s1);
    check("audio_unused_bits", lo, 0);
  endtask
  task automatic press();
    int pulses, seen;
    pulses = 0; seen = -1;
    advance_raw = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (advance_pulse) begin
        pulses++;
        if (seen < 0) seen = c;
      end
    end
    check("adv_pulse_count", pulses, 1);
    check("adv_pulse_latency", seen, 3);
    advance_raw = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (advance_pulse) pulses++;
    end
    check("adv_no_pulse_on_release", pulses, 0);
  endtask
  initial begin
    int ones;
    logic mx, my, mhp, nx, ny;
    logic [11:0] rr;
    logic ra, rh, rv, rd;
    vec[0] = '{4'h6, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h89};
    vec[1] = '{4'h6, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h98};
    vec[2] = '{4'h6, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h09};
    vec[3] = '{4'h6, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h09};
    vec[4] = '{4'h6, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h98};
    vec[5] = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF};
    vec[6] = '{4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
    vec[7] = '{4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 8'h88};
    vec[8] = '{4'h6, 4'hB, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDA};
    vec[9] = '{4'h6, 4'hB, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFA};
    drive(12'hFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.audio_sample = 16'hA5C3;
    bus.audio_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo_out", bus.uo_out, 8'h88);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_adv_pulse", advance_pulse, 1'b0);
    check("uio_oe", bus.uio_oe, 8'hC0);
    rst_n = 1'b1;
    bus.audio_valid = 1'b0;
    @(posedge clk); #1;
    check("first_pixel_lat1", bus.uo_out, 8'h88);
    @(posedge clk); #1;
    check("first_pixel_lat2", bus.uo_out, 8'h77);
    ones = 0;
    repeat (300) begin
      if (bus.uio_out != 8'h00) ones++;
      @(posedge clk); #1;
    end
    check("audio_valid_in_reset_ignored", ones, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10 + PD - 1; i++) begin
      if (i < 10) drive({vec[i].r, vec[i].g, vec[i].b}, vec[i].act, vec[i].hs, vec[i].vs, vec[i].d);
      @(posedge clk); #1;
      if (i >= PD - 1) check($sformatf("vec%0d", i - PD + 1), bus.uo_out, vec[i-PD+1].exp);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mx = 1'b0; my = 1'b0; mhp = 1'b0;
    exq.delete();
    repeat (1500) begin
      rr = 12'($urandom);
      ra = $urandom_range(0, 3) != 0;
      rh = $urandom_range(0, 7) == 0;
      rv = $urandom_range(0, 31) == 0;
      rd = 1'($urandom);
      drive(rr, ra, rh, rv, rd);
      exq.push_back(model(rr, ra, rh, rv, rd, mx, my));
      @(posedge clk);
      nx = ra ? ~mx : 1'b0;
      ny = rv ? 1'b0 : (rh && !mhp) ? ~my : my;
      mhp = rh; mx = nx; my = ny;
      #1;
      if (exq.size() == PD) check("rand_uo_out", bus.uo_out, exq.pop_front());
    end
    audio_window(64, 0);
    audio_window(0, 255);
    audio_window(255, 128);
    repeat (3) audio_window($urandom_range(0, 255), $urandom_range(0, 255));
    press();
    press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
